// File: rtl/maj_net_tt_sequencer.sv
// Time-shares one MAJ3 evaluator across a programmed majority-gate network,
// sweeping all input vectors to build the final gate's truth table.
module maj_net_tt_sequencer #(
  parameter int MAX_GATES  = 8,
  parameter int NUM_INPUTS = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         prog_we,
  input  logic [2:0]   prog_addr,
  input  logic [14:0]  prog_data,
  input  logic [3:0]   num_gates,
  input  logic         start,
  input  logic [127:0] exp_tt,
  output logic         busy,
  output logic         done,
  output logic [127:0] tt,
  output logic         match,
  output logic         err
);

  localparam int NUM_VECS = 1 << NUM_INPUTS;

  typedef enum logic [1:0] {IDLE, LOAD, EVAL, FIN} state_t;

  state_t               state, state_nxt;
  logic [14:0]          prog [MAX_GATES];
  logic [MAX_GATES-1:0] res;
  logic [3:0]           n_q;
  logic [127:0]         exp_q;
  logic [6:0]           v;
  logic [2:0]           g;

  logic [14:0] word;
  logic [3:0]  sel_j;
  logic        raw_j;
  logic [2:0]  op;
  logic        gate_out, fwd_ref, last_gate, last_vec, n_bad;

  // Operand fetch and the shared MAJ3 for gate g of vector v.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    word    = prog[g];
    fwd_ref = 1'b0;
    op      = '0;
    sel_j   = '0;
    raw_j   = 1'b0;
    for (int j = 0; j < 3; j++) begin
      sel_j = word[4*j +: 4];
      if (sel_j == 4'd0) begin
        raw_j = 1'b0;
      end else if (!sel_j[3]) begin
        raw_j = v[sel_j[2:0] - 3'd1];
      end else if (sel_j[2:0] < g) begin
        raw_j = res[sel_j[2:0]];
      end else begin
        // Gate not yet computed for this vector: read as 0 and flag it.
        raw_j   = 1'b0;
        fwd_ref = 1'b1;
      end
      op[j] = raw_j ^ word[12+j];
    end
    gate_out  = (op[0] & op[1]) | (op[0] & op[2]) | (op[1] & op[2]);
    last_gate = ({1'b0, g} == n_q - 4'd1);
    last_vec  = (v == 7'(NUM_VECS - 1));
    n_bad     = (num_gates == 4'd0) || (num_gates > 4'(MAX_GATES));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = n_bad ? FIN : EVAL;
      EVAL:    if (last_gate && last_vec) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == LOAD) || (state == EVAL);
  assign done = (state == FIN);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the program memory is reset explicitly because a reset must leave an empty program.
    if (!rst_n) begin
      for (int i = 0; i < MAX_GATES; i++) prog[i] <= '0;
    end else if (prog_we && state == IDLE && {1'b0, prog_addr} < 4'(MAX_GATES)) begin
      prog[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res   <= '0;
      n_q   <= '0;
      exp_q <= '0;
      v     <= '0;
      g     <= '0;
      tt    <= '0;
      match <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          n_q   <= num_gates;
          exp_q <= exp_tt;
          tt    <= '0;
          v     <= '0;
          g     <= '0;
          err   <= n_bad;
          match <= n_bad ? (exp_tt == '0) : 1'b0;
        end
        EVAL: begin
          res[g] <= gate_out;
          if (fwd_ref) err <= 1'b1;
          if (last_gate) begin
            tt[v] <= gate_out;
            g     <= '0;
            v     <= v + 7'd1;
            // tt[v] is still clear here, so OR-ing in the new bit gives the final table.
            if (last_vec) match <= ((tt | (128'(gate_out) << v)) == exp_q);
          end else begin
            g <= g + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
